// File: rtl/rover_nav_ctrl.sv
// Rover navigation controller: debounces the IR and colour sensors, times turns and colour
// displays, and decodes the current state into motor and LED commands.
module rover_nav_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned TURN_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES = 5000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       go_i,
  input  logic       pause_i,
  input  logic       halt_i,
  input  logic       irr_i,
  input  logic       irl_i,
  input  logic       red_i,
  input  logic       blue_i,
  input  logic       green_i,
  output logic [2:0] state_code_o,
  output logic [1:0] motor_l_o,
  output logic [1:0] motor_r_o,
  output logic [2:0] color_led_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    StStop   = 3'b000,
    StSearch = 3'b001,
    StTurnL  = 3'b010,
    StTurnR  = 3'b011,
    StRed    = 3'b100,
    StBlue   = 3'b101,
    StGreen  = 3'b110,
    StPause  = 3'b111
  } state_e;

  localparam int NumSens = 5;
  localparam logic [CNT_W-1:0] One      = CNT_W'(1);
  localparam logic [CNT_W-1:0] DebMax   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0] TurnLoad = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);

  // Sensor index: 0 irr, 1 irl, 2 red, 3 blue, 4 green.
  logic [NumSens-1:0] raw;
  logic [NumSens-1:0] filt_q, filt_d;
  logic [CNT_W-1:0]   deb_cnt_q [NumSens];
  logic [CNT_W-1:0]   deb_cnt_d [NumSens];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  // Arm bits: 0 red, 1 blue, 2 green.
  logic [2:0]       arm_q, arm_d;

  assign raw = {green_i, blue_i, red_i, irl_i, irr_i};

  // Debounce: a filtered bit flips after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NumSens; i++) begin
      deb_cnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (deb_cnt_q[i] + One == DebMax) begin
          filt_d[i] = raw[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + One;
        end
      end
    end
  end

  // Next state, turn/hold timer and colour arm bits.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    arm_d   = arm_q;

    // Re-arm a colour once its sensor has dropped, outside its own display state.
    if (!filt_q[2] && state_q != StRed)   arm_d[0] = 1'b1;
    if (!filt_q[3] && state_q != StBlue)  arm_d[1] = 1'b1;
    if (!filt_q[4] && state_q != StGreen) arm_d[2] = 1'b1;

    if (halt_i) begin
      state_d = StStop;
    end else begin
      case (state_q)
        StStop: begin
          if (go_i) state_d = StSearch;
        end
        StSearch: begin
          if (pause_i) begin
            state_d = StPause;
          end else if (filt_q[0]) begin
            state_d = StTurnL;
            timer_d = TurnLoad;
          end else if (filt_q[1]) begin
            state_d = StTurnR;
            timer_d = TurnLoad;
          end else if (filt_q[2] && arm_q[0]) begin
            state_d  = StRed;
            timer_d  = HoldLoad;
            arm_d[0] = 1'b0;
          end else if (filt_q[3] && arm_q[1]) begin
            state_d  = StBlue;
            timer_d  = HoldLoad;
            arm_d[1] = 1'b0;
          end else if (filt_q[4] && arm_q[2]) begin
            state_d  = StGreen;
            timer_d  = HoldLoad;
            arm_d[2] = 1'b0;
          end
        end
        StTurnL, StTurnR: begin
          if (pause_i) begin
            state_d = StPause;
          end else if (timer_q != '0) begin
            timer_d = timer_q - One;
          end else if ((state_q == StTurnL) ? filt_q[0] : filt_q[1]) begin
            // Still obstructed: keep turning for another full period.
            timer_d = TurnLoad;
          end else begin
            state_d = StSearch;
          end
        end
        StRed, StBlue, StGreen: begin
          if (timer_q == '0) begin
            state_d = StSearch;
          end else begin
            timer_d = timer_q - One;
          end
        end
        StPause: begin
          if (go_i && !pause_i) state_d = StSearch;
        end
        default: state_d = StStop;
      endcase
    end
  end

  // State, timer, arm and debounce registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StStop;
      timer_q <= '0;
      arm_q   <= 3'b111;
      filt_q  <= '0;
      for (int i = 0; i < NumSens; i++) deb_cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      arm_q   <= arm_d;
      filt_q  <= filt_d;
      for (int i = 0; i < NumSens; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // Outputs decode the state register directly.
  always_comb begin
    state_code_o = state_q;
    motor_l_o    = 2'b00;
    motor_r_o    = 2'b00;
    color_led_o  = 3'b000;
    busy_o       = 1'b0;
    case (state_q)
      StSearch: begin
        motor_l_o = 2'b01;
        motor_r_o = 2'b01;
      end
      StTurnL: begin
        motor_l_o = 2'b10;
        motor_r_o = 2'b01;
        busy_o    = 1'b1;
      end
      StTurnR: begin
        motor_l_o = 2'b01;
        motor_r_o = 2'b10;
        busy_o    = 1'b1;
      end
      StRed: begin
        color_led_o = 3'b100;
        busy_o      = 1'b1;
      end
      StBlue: begin
        color_led_o = 3'b010;
        busy_o      = 1'b1;
      end
      StGreen: begin
        color_led_o = 3'b001;
        busy_o      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rover_nav_ctrl.sv
// Bench for rover_nav_ctrl: directed vector table plus randomized run against a behavioural model.
module tb_rover_nav_ctrl;

  localparam int DEB  = 4;
  localparam int TURN = 10;
  localparam int HOLD = 20;

  localparam int S_STOP = 0, S_SEARCH = 1, S_TL = 2, S_TR = 3;
  localparam int S_RED = 4, S_PAUSE = 7;

  logic clk = 1'b0;
  logic rst, go, pause, halt, irr, irl, red, blue, green;
  logic [2:0] state_code;
  logic [1:0] motor_l, motor_r;
  logic [2:0] color_led;
  logic busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rover_nav_ctrl #(
    .CNT_W      (16),
    .DEB_CYCLES (DEB),
    .TURN_CYCLES(TURN),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .go_i        (go),
    .pause_i     (pause),
    .halt_i      (halt),
    .irr_i       (irr),
    .irl_i       (irl),
    .red_i       (red),
    .blue_i      (blue),
    .green_i     (green),
    .state_code_o(state_code),
    .motor_l_o   (motor_l),
    .motor_r_o   (motor_r),
    .color_led_o (color_led),
    .busy_o      (busy)
  );

  // Behavioural model: sensor index 0 irr, 1 irl, 2 red, 3 blue, 4 green.
  int m_state;
  int m_timer;
  int m_cnt [5];
  bit m_f   [5];
  bit m_arm [3];
  bit model_valid = 1'b0;

  // {motor_l, motor_r, color_led, busy} for a given state code.
  function automatic logic [7:0] exp_outs(input int st);
    case (st)
      1:       return {2'b01, 2'b01, 3'b000, 1'b0};
      2:       return {2'b10, 2'b01, 3'b000, 1'b1};
      3:       return {2'b01, 2'b10, 3'b000, 1'b1};
      4:       return {2'b00, 2'b00, 3'b100, 1'b1};
      5:       return {2'b00, 2'b00, 3'b010, 1'b1};
      6:       return {2'b00, 2'b00, 3'b001, 1'b1};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic g, input logic p, input logic h,
                            input logic [4:0] raw);
    int ns, nt;
    bit narm [3];
    bit took;
    if (r) begin
      m_state = S_STOP;
      m_timer = 0;
      for (int i = 0; i < 5; i++) begin
        m_cnt[i] = 0;
        m_f[i]   = 1'b0;
      end
      for (int c = 0; c < 3; c++) m_arm[c] = 1'b1;
      model_valid = 1'b1;
      return;
    end
    ns   = m_state;
    nt   = m_timer;
    narm = m_arm;
    for (int c = 0; c < 3; c++)
      if (!m_f[2+c] && m_state != S_RED + c) narm[c] = 1'b1;
    if (h) begin
      ns = S_STOP;
    end else if (m_state == S_STOP) begin
      if (g) ns = S_SEARCH;
    end else if (m_state == S_SEARCH) begin
      took = 1'b0;
      if (p) ns = S_PAUSE;
      else if (m_f[0]) begin ns = S_TL; nt = TURN - 1; end
      else if (m_f[1]) begin ns = S_TR; nt = TURN - 1; end
      else begin
        for (int c = 0; c < 3; c++) begin
          if (!took && m_f[2+c] && m_arm[c]) begin
            ns = S_RED + c;
            nt = HOLD - 1;
            narm[c] = 1'b0;
            took = 1'b1;
          end
        end
      end
    end else if (m_state == S_TL || m_state == S_TR) begin
      if (p) ns = S_PAUSE;
      else if (m_timer > 0) nt = m_timer - 1;
      else if (m_f[m_state == S_TL ? 0 : 1]) nt = TURN - 1;
      else ns = S_SEARCH;
    end else if (m_state == S_PAUSE) begin
      if (g && !p) ns = S_SEARCH;
    end else begin
      if (m_timer == 0) ns = S_SEARCH;
      else nt = m_timer - 1;
    end
    for (int i = 0; i < 5; i++) begin
      if (raw[i] == m_f[i]) m_cnt[i] = 0;
      else begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_f[i]   = raw[i];
          m_cnt[i] = 0;
        end
      end
    end
    m_state = ns;
    m_timer = nt;
    m_arm   = narm;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs now applied, then compare after the edge.
  task automatic tick();
    model_step(rst, go, pause, halt, {green, blue, red, irl, irr});
    @(posedge clk);
    #1;
    if (model_valid)
      check("model", {5'b0, state_code, motor_l, motor_r, color_led, busy},
            {5'b0, 3'(m_state), exp_outs(m_state)});
  endtask

  typedef struct {
    logic [8:0] in;   // {rst, go, pause, halt, irr, irl, red, blue, green}
    int         cyc;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [8:0] in, input int cyc, input logic [2:0] st);
    vec_t x;
    x.in  = in;
    x.cyc = cyc;
    x.st  = st;
    return x;
  endfunction

  initial begin
    {rst, go, pause, halt, irr, irl, red, blue, green} = '0;
    //                     r g p h rr rl R B G
    vecs.push_back(v(9'b1_0_0_0_0_0_0_0_0, 3, 3'b000));
    vecs.push_back(v(9'b0_1_0_0_0_0_0_0_0, 1, 3'b001));
    // Short irr glitch, then a steady obstacle and a clean turn.
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 3, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 2, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 4, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 1, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 9, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 1, 3'b001));
    // Obstacle held past expiry: two reloads.
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 5, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 10, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 10, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 9, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 1, 3'b001));
    // irl and red together: turn first, then red display, no re-trigger until red drops.
    vecs.push_back(v(9'b0_0_0_0_0_1_1_0_0, 4, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_1_1_0_0, 1, 3'b011));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 9, 3'b011));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 1, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 1, 3'b100));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 19, 3'b100));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 1, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 5, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 6, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 4, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 1, 3'b100));
    vecs.push_back(v(9'b0_0_0_0_0_0_1_0_0, 20, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 6, 3'b001));
    // Pause mid-turn, go+pause holds, go alone resumes.
    vecs.push_back(v(9'b0_0_0_0_0_1_0_0_0, 5, 3'b011));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 3, 3'b011));
    vecs.push_back(v(9'b0_0_1_0_0_0_0_0_0, 1, 3'b111));
    vecs.push_back(v(9'b0_1_1_0_0_0_0_0_0, 3, 3'b111));
    vecs.push_back(v(9'b0_1_0_0_0_0_0_0_0, 1, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 2, 3'b001));
    // Halt in green; green still high after restart does not re-trigger.
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_1, 4, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_1, 1, 3'b110));
    vecs.push_back(v(9'b0_0_0_1_0_0_0_0_1, 1, 3'b000));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_1, 3, 3'b000));
    vecs.push_back(v(9'b0_1_0_0_0_0_0_0_1, 1, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_1, 3, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 6, 3'b001));
    // Reset mid-turn; blue held through reset is ignored until go.
    vecs.push_back(v(9'b0_0_0_0_1_0_0_0_0, 5, 3'b010));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_1_0, 2, 3'b010));
    vecs.push_back(v(9'b1_0_0_0_0_0_0_1_0, 2, 3'b000));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_1_0, 8, 3'b000));
    vecs.push_back(v(9'b0_1_0_0_0_0_0_1_0, 1, 3'b001));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_1_0, 1, 3'b101));
    vecs.push_back(v(9'b0_0_0_1_0_0_0_1_0, 1, 3'b000));
    vecs.push_back(v(9'b0_0_0_0_0_0_0_0_0, 6, 3'b000));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      {rst, go, pause, halt, irr, irl, red, blue, green} = vecs[i].in;
      for (int k = 0; k < vecs[i].cyc; k++) tick();
      check($sformatf("row%0d.state", i), {13'b0, state_code}, {13'b0, vecs[i].st});
      check($sformatf("row%0d.outs", i), {8'b0, motor_l, motor_r, color_led, busy},
            {8'b0, exp_outs(int'(vecs[i].st))});
    end

    // Randomized run against the model.
    {rst, go, pause, halt, irr, irl, red, blue, green} = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      go    = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 24) == 0);
      halt  = ($urandom_range(0, 299) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 11) == 0) irr   = ~irr;
      if ($urandom_range(0, 11) == 0) irl   = ~irl;
      if ($urandom_range(0, 11) == 0) red   = ~red;
      if ($urandom_range(0, 11) == 0) blue  = ~blue;
      if ($urandom_range(0, 11) == 0) green = ~green;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
